pixel_write_port: RTL and testbench

- Write side of the 320×240 8-bit (RGB332) pixel framebuffer SRAM. The pixel engine is the read side.
- Accepts CPU/bus pixel writes through a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into SRAM only on cycles when the pixel engine is not sampling SRAM.
- A top-level mux gives the SRAM address/data bus to this block whenever sram_we is high.

---
 rtl/gpu_fb_pkg.sv | 44 ++++
 rtl/pixel_write_fifo.sv | 51 +++++
 rtl/pixel_write_port.sv | 83 ++++++++
 tb/tb_pixel_write_port.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fb_pkg.sv
// Shared framebuffer geometry and the pixel-engine SRAM read-slot predicate.
package gpu_fb_pkg;

    localparam int unsigned HSTART_HDMI = 159;
    localparam int unsigned VSTART_HDMI = 44;

    localparam int unsigned FB_WIDTH    = 320;
    localparam int unsigned FB_HEIGHT   = 240;
    localparam int unsigned FB_SIZE     = 76800;

    localparam int unsigned ACTIVE_W    = 640;
    localparam int unsigned ACTIVE_H    = 480;

    // One queued framebuffer write: linear pixel address plus RGB332 value.
    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } fb_wr_t;

    // High on cycles where the pixel engine samples SRAM: the first screen
    // pixel of each 2x2 (normal) or 4x4 (half-res) block inside the active area.
    function automatic logic is_read_slot(
        input logic [11:0] h_count,
        input logic [11:0] v_count,
        input logic        half_res,
        input logic [11:0] hstart,
        input logic [11:0] vstart
    );
        logic [11:0] px;
        logic [11:0] ln;
        logic        in_video;
        logic        first;
        px       = h_count - (hstart + 12'd1);
        ln       = v_count - (vstart + 12'd1);
        in_video = (h_count > hstart) && (v_count > vstart) &&
                   (px < 12'(ACTIVE_W)) && (ln < 12'(ACTIVE_H));
        if (half_res)
            first = (ln[1:0] == 2'b00) && (px[1:0] == 2'b00);
        else
            first = (ln[0] == 1'b0) && (px[0] == 1'b0);
        return in_video && first;
    endfunction

endpackage

// File: rtl/pixel_write_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head word is visible combinationally.
module pixel_write_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 25
) (
    input  logic                     clkPixel,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (level == (PW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[PW-1:0]];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clkPixel) begin
        if (do_push)
            mem[wptr[PW-1:0]] <= din;
    end

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clkPixel or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_write_port.sv
// Framebuffer SRAM write port: buffers bus writes and drains them around pixel-engine fetches.
module pixel_write_port
    import gpu_fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HSTART     = HSTART_HDMI,
    parameter int unsigned VSTART     = VSTART_HDMI
) (
    input  logic                          clkPixel,
    input  logic                          resetn,
    input  logic [11:0]                   h_count,
    input  logic [11:0]                   v_count,
    input  logic                          halfRes,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [16:0]                   wr_addr,
    input  logic [7:0]                    wr_data,
    output logic                          sram_we,
    output logic [16:0]                   sram_waddr,
    output logic [7:0]                    sram_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          addr_err
);

    logic   fifo_full;
    logic   fifo_empty;
    logic   accept;
    logic   in_range;
    logic   push;
    logic   read_slot;
    fb_wr_t head_word;
    fb_wr_t last_q;
    fb_wr_t shown;

    assign wr_ready  = !fifo_full;
    assign accept    = wr_valid && wr_ready;
    assign in_range  = (wr_addr < 17'(FB_SIZE));
    assign push      = accept && in_range;
    assign read_slot = is_read_slot(h_count, v_count, halfRes, 12'(HSTART), 12'(VSTART));
    assign sram_we   = !fifo_empty && !read_slot;

    pixel_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fb_wr_t))
    ) u_fifo (
        .clkPixel (clkPixel),
        .resetn   (resetn),
        .push     (push),
        .pop      (sram_we),
        .din      ({wr_addr, wr_data}),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .head     (head_word)
    );

    // Remember the last word written so the SRAM bus holds steady once the FIFO empties.
    always_ff @(posedge clkPixel or negedge resetn) begin
        if (!resetn)
            last_q <= '0;
        else if (sram_we)
            last_q <= head_word;
    end

    // Sticky out-of-range flag; only reset clears it.
    always_ff @(posedge clkPixel or negedge resetn) begin
        if (!resetn)
            addr_err <= 1'b0;
        else if (accept && !in_range)
            addr_err <= 1'b1;
    end

    // Present the FIFO head, or the held word when nothing is queued.
    always_comb begin
        shown = head_word;
        if (fifo_empty)
            shown = last_q;
    end

    assign sram_waddr = shown.addr;
    assign sram_wdata = shown.data;

endmodule

// File: tb/tb_pixel_write_port.sv
module tb_pixel_write_port;

    logic        clkPixel = 1'b0;
    logic        resetn;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        halfRes;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        sram_we;
    logic [16:0] sram_waddr;
    logic [7:0]  sram_wdata;
    logic [2:0]  fifo_level;
    logic        addr_err;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [24:0] exp_q[$];

    pixel_write_port #(
        .FIFO_DEPTH (4),
        .HSTART     (159),
        .VSTART     (44)
    ) dut (
        .clkPixel   (clkPixel),
        .resetn     (resetn),
        .h_count    (h_count),
        .v_count    (v_count),
        .halfRes    (halfRes),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sram_we    (sram_we),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata),
        .fifo_level (fifo_level),
        .addr_err   (addr_err)
    );

    always #20 clkPixel = ~clkPixel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every SRAM write must match the oldest expected write.
    always @(negedge clkPixel) begin
        if (resetn === 1'b1 && sram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         sram_waddr, sram_wdata);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                chk("sram_write", {7'b0, sram_waddr, sram_wdata}, {7'b0, e});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clkPixel);
        #1;
    endtask

    task automatic at_pos(input int v, input int h);
        v_count = 12'(v);
        h_count = 12'(h);
    endtask

    task automatic expect_we(input string name, input logic exp);
        @(negedge clkPixel);
        chk(name, {31'b0, sram_we}, {31'b0, exp});
        cyc();
    endtask

    task automatic push(input logic [16:0] a, input logic [7:0] d, input bit track);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clkPixel);
            if (wr_ready === 1'b1) begin
                if (track && a < 17'd76800)
                    exp_q.push_back({a, d});
                cyc();
                wr_valid = 1'b0;
                return;
            end
            cyc();
        end
        n_total++;
        $display("FAIL push_timeout: wr_ready stayed 0, expected 1 within 50 cycles");
        wr_valid = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        h_count  = '0;
        v_count  = '0;
        halfRes  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;

        // 1. reset
        repeat (3) @(posedge clkPixel);
        @(negedge clkPixel);
        chk("rst_hold_we", {31'b0, sram_we}, 0);
        chk("rst_hold_level", {29'b0, fifo_level}, 0);
        @(posedge clkPixel);
        #1;
        resetn = 1'b1;
        @(negedge clkPixel);
        chk("rst_ready", {31'b0, wr_ready}, 1);
        chk("rst_we", {31'b0, sram_we}, 0);
        chk("rst_level", {29'b0, fifo_level}, 0);
        chk("rst_err", {31'b0, addr_err}, 0);
        chk("rst_waddr", {15'b0, sram_waddr}, 0);
        chk("rst_wdata", {24'b0, sram_wdata}, 0);
        cyc();

        // 2. blanking write drains on the next cycle
        at_pos(10, 20);
        push(17'h00141, 8'hE3, 1);
        expect_we("blank_we", 1'b1);
        @(negedge clkPixel);
        chk("blank_level", {29'b0, fifo_level}, 0);
        chk("blank_we_idle", {31'b0, sram_we}, 0);
        chk("hold_waddr", {15'b0, sram_waddr}, 32'h141);
        chk("hold_wdata", {24'b0, sram_wdata}, 32'hE3);
        cyc();

        // 3. normal-mode read slots
        at_pos(45, 100);
        push(17'h00200, 8'h11, 1);
        at_pos(45, 160);
        expect_we("n_slot_px0", 1'b0);
        at_pos(45, 161);
        expect_we("n_px1", 1'b1);
        at_pos(46, 100);
        push(17'h00201, 8'h22, 1);
        at_pos(46, 160);
        expect_we("n_odd_line", 1'b1);

        // 4. half-res read slots
        halfRes = 1'b1;
        at_pos(45, 160);
        for (int i = 0; i < 4; i++)
            push(17'(32'h300 + i), 8'(8'h30 + i), 1);
        @(negedge clkPixel);
        chk("h_full_ready", {31'b0, wr_ready}, 0);
        chk("h_full_level", {29'b0, fifo_level}, 4);
        chk("h_slot160", {31'b0, sram_we}, 0);
        cyc();
        at_pos(45, 161); expect_we("h_161", 1'b1);
        at_pos(45, 162); expect_we("h_162", 1'b1);
        at_pos(45, 163); expect_we("h_163", 1'b1);
        at_pos(45, 164); expect_we("h_slot164", 1'b0);
        at_pos(45, 165); expect_we("h_165", 1'b1);
        for (int vv = 46; vv <= 48; vv++) begin
            at_pos(45, 160);
            push(17'(32'h400 + vv * 2), 8'(vv), 1);
            push(17'(32'h401 + vv * 2), 8'(vv + 100), 1);
            at_pos(vv, 160);
            expect_we("h_line_unblk160", 1'b1);
            at_pos(vv, 164);
            expect_we("h_line_unblk164", 1'b1);
        end
        halfRes = 1'b0;

        // 5. back-pressure on a normal-mode fetch line
        at_pos(45, 160);
        for (int i = 0; i < 4; i++)
            push(17'(32'h500 + i), 8'(8'h50 + i), 1);
        @(negedge clkPixel);
        chk("bp_ready_low", {31'b0, wr_ready}, 0);
        chk("bp_level4", {29'b0, fifo_level}, 4);
        cyc();
        wr_valid = 1'b1;
        wr_addr  = 17'h00504;
        wr_data  = 8'h54;
        for (int h = 161; h <= 171; h++) begin
            at_pos(45, h);
            @(negedge clkPixel);
            chk("bp_we", {31'b0, sram_we}, ((h % 2 == 1) && (h <= 169)) ? 1 : 0);
            if (h == 161)
                chk("bp_no_pushthrough", {31'b0, wr_ready}, 0);
            if (h == 162)
                chk("bp_ready_after_pop", {31'b0, wr_ready}, 1);
            if (wr_valid && wr_ready === 1'b1) begin
                exp_q.push_back({17'h00504, 8'h54});
                cyc();
                wr_valid = 1'b0;
            end else begin
                cyc();
            end
        end
        chk("bp_w4_taken", {31'b0, wr_valid}, 0);
        wr_valid = 1'b0;

        // 6. range error, boundary address, reset mid-drain
        at_pos(10, 20);
        push(17'd76800, 8'hAA, 1);
        @(negedge clkPixel);
        chk("err_set", {31'b0, addr_err}, 1);
        chk("err_level", {29'b0, fifo_level}, 0);
        chk("err_no_we", {31'b0, sram_we}, 0);
        cyc();
        push(17'd76799, 8'h5A, 1);
        expect_we("last_addr_we", 1'b1);
        @(negedge clkPixel);
        chk("err_sticky", {31'b0, addr_err}, 1);
        cyc();
        at_pos(45, 160);
        for (int i = 0; i < 3; i++)
            push(17'(32'h600 + i), 8'(8'h60 + i), 0);
        @(negedge clkPixel);
        chk("pre_rst_level", {29'b0, fifo_level}, 3);
        cyc();
        resetn = 1'b0;
        at_pos(10, 20);
        @(negedge clkPixel);
        chk("mid_rst_we", {31'b0, sram_we}, 0);
        chk("mid_rst_level", {29'b0, fifo_level}, 0);
        chk("mid_rst_err", {31'b0, addr_err}, 0);
        cyc();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkPixel);
            chk("post_rst_we", {31'b0, sram_we}, 0);
            chk("post_rst_level", {29'b0, fifo_level}, 0);
            cyc();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
